// File: rtl/line_window_gen.sv
// K x K sliding-window generator over K+1 internal line banks with valid/ready on both sides.
// Emits (IMG_WIDTH-K+1) x (IMG_HEIGHT-K+1) windows per frame, no border padding.
module line_window_gen #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int DATA_W     = 8,
  parameter int K          = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_W-1:0]       i_pixel_data,
  input  logic                    i_pixel_data_valid,
  output logic                    o_pixel_ready,
  output logic [K*K*DATA_W-1:0]   o_window,
  output logic                    o_window_valid,
  input  logic                    i_window_ready,
  output logic                    o_line_done,
  output logic                    o_frame_done
);

  localparam int NB = K + 1;
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam int BW = $clog2(K + 1);
  localparam int LW = $clog2(K + 2);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PRIME     = 3'd1;
  localparam logic [2:0] STREAM    = 3'd2;
  localparam logic [2:0] LINE_END  = 3'd3;
  localparam logic [2:0] FRAME_END = 3'd4;

  logic [DATA_W-1:0] mem [NB][IMG_WIDTH];
  logic [DATA_W-1:0] win [K][K];
  logic [BW-1:0]     bank_sel [K];
  logic [BW:0]       bank_sum;

  logic [CW-1:0] wr_col, rd_col;
  logic [BW-1:0] wr_bank, rd_bank;
  logic [RW-1:0] wr_row, out_row;
  logic [LW-1:0] lines_full;
  logic [2:0]    state;
  logic          started, line_last, win_valid;
  logic          px_fire, wr_wrap, beat, rd_issue, line_end, frame_end;

  function automatic logic [BW-1:0] bank_next(input logic [BW-1:0] b);
    return (b == BW'(K)) ? '0 : b + 1'b1;
  endfunction

  always_comb begin
    px_fire   = i_pixel_data_valid && o_pixel_ready;
    wr_wrap   = px_fire && (wr_col == CW'(IMG_WIDTH - 1));
    beat      = win_valid && i_window_ready;
    // No read after the window holding column IMG_WIDTH-1; that beat closes the line.
    rd_issue  = (state == PRIME) || ((state == STREAM) && beat && !line_last);
    line_end  = (state == LINE_END);
    frame_end = (state == FRAME_END);
  end

  always_comb begin
    bank_sum = '0;
    for (int unsigned r = 0; r < K; r++) begin
      bank_sum = {1'b0, rd_bank} + (BW+1)'(r);
      if (bank_sum >= (BW+1)'(NB)) bank_sum = bank_sum - (BW+1)'(NB);
      bank_sel[r] = bank_sum[BW-1:0];
    end
  end

  always_comb begin
    o_pixel_ready  = started && (lines_full < LW'(NB)) && (wr_row < RW'(IMG_HEIGHT));
    o_window_valid = win_valid;
    o_line_done    = beat && line_last;
    o_frame_done   = beat && line_last && (out_row == RW'(IMG_HEIGHT - K));
    o_window       = '0;
    for (int unsigned r = 0; r < K; r++)
      for (int unsigned c = 0; c < K; c++)
        o_window[(r*K + c)*DATA_W +: DATA_W] = win[r][c];
  end

  always_ff @(posedge i_clk) begin
    if (px_fire) mem[wr_bank][wr_col] <= i_pixel_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      started    <= 1'b0;
      wr_col     <= '0;
      wr_bank    <= '0;
      wr_row     <= '0;
      lines_full <= '0;
    end else begin
      started <= 1'b1;
      if (frame_end) begin
        wr_col  <= '0;
        wr_bank <= '0;
        wr_row  <= '0;
      end else if (px_fire) begin
        if (wr_wrap) begin
          wr_col  <= '0;
          wr_bank <= bank_next(wr_bank);
          wr_row  <= wr_row + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      if (frame_end)                 lines_full <= '0;
      else if (wr_wrap && !line_end) lines_full <= lines_full + 1'b1;
      else if (!wr_wrap && line_end) lines_full <= lines_full - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      rd_col    <= '0;
      rd_bank   <= '0;
      out_row   <= '0;
      line_last <= 1'b0;
      win_valid <= 1'b0;
      for (int unsigned r = 0; r < K; r++)
        for (int unsigned c = 0; c < K; c++)
          win[r][c] <= '0;
    end else begin
      // The RAM output register is the window's rightmost column, so a read lands
      // directly in the window and there is never a read in flight during a stall.
      if (rd_issue) begin
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned c = 0; c + 1 < K; c++)
            win[r][c] <= win[r][c+1];
          win[r][K-1] <= mem[bank_sel[r]][rd_col];
        end
        line_last <= (rd_col == CW'(IMG_WIDTH - 1));
        rd_col    <= (rd_col == CW'(IMG_WIDTH - 1)) ? '0 : rd_col + 1'b1;
      end
      case (state)
        IDLE:   if (lines_full >= LW'(K)) state <= PRIME;
        PRIME:  if (rd_col == CW'(K - 1)) begin
                  state     <= STREAM;
                  win_valid <= 1'b1;
                end
        STREAM: if (beat && line_last) begin
                  state     <= LINE_END;
                  win_valid <= 1'b0;
                end
        LINE_END: begin
          rd_bank   <= bank_next(rd_bank);
          out_row   <= out_row + 1'b1;
          rd_col    <= '0;
          line_last <= 1'b0;
          state     <= (out_row == RW'(IMG_HEIGHT - K)) ? FRAME_END : IDLE;
        end
        FRAME_END: begin
          rd_bank <= '0;
          out_row <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Scoreboard bench for line_window_gen: two instances (K=3 8x6 and K=5 7x12); expected windows
// are cut directly from each generated image and matched by a monitor on every output beat.
module tb_line_window_gen;

  localparam int DW = 8;
  localparam int KA = 3, WA = 8, HA = 6;
  localparam int KB = 5, WB = 7, HB = 12;

  typedef struct packed {
    logic [199:0] win;
    logic         ld;
    logic         fd;
  } exp_t;

  logic clk, rst_n;
  logic [DW-1:0]       a_data, b_data;
  logic                a_valid, b_valid, a_pready, b_pready;
  logic [KA*KA*DW-1:0] a_win;
  logic [KB*KB*DW-1:0] b_win;
  logic                a_wvalid, b_wvalid, a_wready, b_wready;
  logic                a_ld, b_ld, a_fd, b_fd;

  line_window_gen #(.IMG_WIDTH(WA), .IMG_HEIGHT(HA), .DATA_W(DW), .K(KA)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(a_data), .i_pixel_data_valid(a_valid),
    .o_pixel_ready(a_pready), .o_window(a_win), .o_window_valid(a_wvalid),
    .i_window_ready(a_wready), .o_line_done(a_ld), .o_frame_done(a_fd));

  line_window_gen #(.IMG_WIDTH(WB), .IMG_HEIGHT(HB), .DATA_W(DW), .K(KB)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(b_data), .i_pixel_data_valid(b_valid),
    .o_pixel_ready(b_pready), .o_window(b_win), .o_window_valid(b_wvalid),
    .i_window_ready(b_wready), .o_line_done(b_ld), .o_frame_done(b_fd));

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int kk[2], ww[2], hh[2];
  int pix_idx[2], t_mark[2], fd_cyc[2], win_cnt[2], ld_cnt[2], fd_cnt[2];
  int gap[2], rmode[2], pstall_cnt[2], starve_at[2], starve_cnt[2];
  bit armed[2], last_acc[2], prev_valid[2], stalled[2], gap_arm[2], chk_gap[2];
  bit starve_pend[2], vgap[2];
  logic [199:0] held[2];
  logic [7:0] img [16][16];
  logic [7:0] pq_a[$], pq_b[$];
  exp_t eq_a[$], eq_b[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input bit ok, input string name, input logic [199:0] act, input logic [199:0] req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int pending(input int i);
    return (i == 0) ? pq_a.size() + eq_a.size() : pq_b.size() + eq_b.size();
  endfunction

  task automatic gen_frame(input int i, input int pattern);
    int k, w, h;
    exp_t e;
    logic [7:0] p;
    k = kk[i]; w = ww[i]; h = hh[i];
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        p = (pattern == 0) ? 8'(r*8 + c) : 8'($urandom_range(255));
        img[r][c] = p;
        if (i == 0) pq_a.push_back(p); else pq_b.push_back(p);
      end
    for (int orow = 0; orow <= h - k; orow++)
      for (int c0 = 0; c0 <= w - k; c0++) begin
        e.win = '0;
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++)
            e.win[(r*k + c)*8 +: 8] = img[orow + r][c0 + c];
        e.ld = (c0 == w - k);
        e.fd = e.ld && (orow == h - k);
        if (i == 0) eq_a.push_back(e); else eq_b.push_back(e);
      end
  endtask

  task automatic drv_step(input int i, input logic rdy, output logic v, output logic [7:0] d);
    bit have;
    have = (i == 0) ? (pq_a.size() > 0) : (pq_b.size() > 0);
    v = 1'b0;
    d = 8'($urandom);
    if (last_acc[i] && rdy) begin
      chk(cyc == fd_cyc[i] + 3, "pixel_ready_reassert", 200'(cyc - fd_cyc[i]), 200'(3));
      last_acc[i] = 1'b0;
    end
    if (!rdy && have && !last_acc[i]) pstall_cnt[i]++;
    if (starve_pend[i] && pix_idx[i] == starve_at[i]) begin
      starve_pend[i] = 1'b0;
      starve_cnt[i]  = 20;
    end
    if (starve_cnt[i] > 0) starve_cnt[i]--;
    else if (vgap[i] && $urandom_range(3) == 0) v = 1'b0;
    else if (have) begin
      v = 1'b1;
      d = (i == 0) ? pq_a[0] : pq_b[0];
    end
    if (v && rdy) begin
      if (i == 0) void'(pq_a.pop_front()); else void'(pq_b.pop_front());
      if (pix_idx[i] == kk[i]*ww[i] - 1) begin
        t_mark[i] = cyc;
        armed[i]  = 1'b1;
      end
      if (pix_idx[i] == ww[i]*hh[i] - 1) last_acc[i] = 1'b1;
      pix_idx[i] = (pix_idx[i] + 1) % (ww[i]*hh[i]);
    end
  endtask

  task automatic mon_step(input int i, input logic wv, input logic wr, input logic [199:0] w,
                          input logic ld, input logic fd);
    exp_t e;
    bit have, fire;
    fire = wv && wr;
    e = '0;
    if (stalled[i]) chk(wv && (w == held[i]), "stall_hold", w, held[i]);
    stalled[i] = wv && !wr;
    held[i] = w;
    if (ld || fd) chk(fire, "pulse_without_beat", {198'b0, ld, fd}, 200'(0));
    if (wv && !prev_valid[i]) begin
      if (armed[i]) begin
        chk(cyc - t_mark[i] == kk[i] + 2, "first_window_latency", 200'(cyc - t_mark[i]), 200'(kk[i] + 2));
        armed[i] = 1'b0;
      end
      if (gap_arm[i]) begin
        if (chk_gap[i]) chk(gap[i] == kk[i] + 2, "line_gap", 200'(gap[i]), 200'(kk[i] + 2));
        gap_arm[i] = 1'b0;
      end
    end else if (!wv && gap_arm[i]) gap[i]++;
    prev_valid[i] = wv;
    if (fire) begin
      if (i == 0) begin
        have = eq_a.size() > 0;
        if (have) e = eq_a.pop_front();
      end else begin
        have = eq_b.size() > 0;
        if (have) e = eq_b.pop_front();
      end
      if (!have) chk(1'b0, "unexpected_window", w, 200'(0));
      else begin
        chk(w == e.win, "window_data", w, e.win);
        chk(ld == e.ld, "line_done", 200'(ld), 200'(e.ld));
        chk(fd == e.fd, "frame_done", 200'(fd), 200'(e.fd));
      end
      win_cnt[i]++;
      if (ld) ld_cnt[i]++;
      if (fd) begin
        fd_cnt[i]++;
        fd_cyc[i] = cyc;
      end
      if (ld && !fd) begin
        gap_arm[i] = 1'b1;
        gap[i] = 0;
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon_step(0, a_wvalid, a_wready, {128'b0, a_win}, a_ld, a_fd);
    mon_step(1, b_wvalid, b_wready, b_win, b_ld, b_fd);
  end

  initial forever begin
    logic v;
    logic [7:0] d;
    @(negedge clk);
    drv_step(0, a_pready, v, d);
    a_valid = v; a_data = d;
    drv_step(1, b_pready, v, d);
    b_valid = v; b_data = d;
  end

  initial begin
    a_wready = 1'b1;
    b_wready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      a_wready = (rmode[0] == 0) ? 1'b1 : ($urandom_range(2) != 0);
      b_wready = (rmode[1] == 0) ? 1'b1 : ($urandom_range(2) != 0);
    end
  end

  task automatic clear_state(input int i);
    pix_idx[i] = 0; armed[i] = 0; last_acc[i] = 0; stalled[i] = 0; gap_arm[i] = 0;
    win_cnt[i] = 0; ld_cnt[i] = 0; fd_cnt[i] = 0; pstall_cnt[i] = 0; fd_cyc[i] = -100;
    starve_pend[i] = 0; starve_cnt[i] = 0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    while (pending(i) > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (pending(i) > 0) chk(1'b0, "timeout_pending_items", 200'(pending(i)), 200'(0));
    repeat (8) @(negedge clk);
  endtask

  task automatic check_counts(input int i, input int nw, input int nl, input int nf);
    chk(win_cnt[i] == nw, "window_count", 200'(win_cnt[i]), 200'(nw));
    chk(ld_cnt[i] == nl, "line_done_count", 200'(ld_cnt[i]), 200'(nl));
    chk(fd_cnt[i] == nf, "frame_done_count", 200'(fd_cnt[i]), 200'(nf));
  endtask

  initial begin
    int n;
    kk[0] = KA; ww[0] = WA; hh[0] = HA;
    kk[1] = KB; ww[1] = WB; hh[1] = HB;
    for (int i = 0; i < 2; i++) begin
      clear_state(i);
      rmode[i] = 0; vgap[i] = 0; chk_gap[i] = 0; prev_valid[i] = 0; starve_at[i] = 0;
    end
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;

    repeat (3) @(posedge clk);
    #1;
    chk(a_pready == 1'b0, "reset_pixel_ready", 200'(a_pready), 200'(0));
    chk(b_pready == 1'b0, "reset_pixel_ready_b", 200'(b_pready), 200'(0));
    chk(a_wvalid == 1'b0, "reset_window_valid", 200'(a_wvalid), 200'(0));
    chk(a_win == '0, "reset_window", {128'b0, a_win}, 200'(0));
    chk({a_ld, a_fd} == 2'b00, "reset_pulses", 200'({a_ld, a_fd}), 200'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk(a_pready == 1'b1, "ready_after_release", 200'(a_pready), 200'(1));
    chk(b_pready == 1'b1, "ready_after_release_b", 200'(b_pready), 200'(1));

    // Test 1: raster pattern, continuous valid and ready
    clear_state(0); chk_gap[0] = 1;
    gen_frame(0, 0);
    wait_done(0, 2000);
    check_counts(0, 24, 4, 1);

    // Test 2: output back-pressure
    clear_state(0); rmode[0] = 1;
    gen_frame(0, 0);
    wait_done(0, 4000);
    check_counts(0, 24, 4, 1);
    chk(pstall_cnt[0] > 0, "pixel_ready_backpressure", 200'(pstall_cnt[0]), 200'(1));
    rmode[0] = 0;

    // Test 3: input starvation mid line 2
    clear_state(0); chk_gap[0] = 0;
    starve_pend[0] = 1; starve_at[0] = 2*WA + 3;
    gen_frame(0, 0);
    wait_done(0, 2000);
    check_counts(0, 24, 4, 1);

    // Test 4: two back-to-back frames, second with random data
    clear_state(0); chk_gap[0] = 1;
    gen_frame(0, 0);
    gen_frame(0, 1);
    wait_done(0, 4000);
    check_counts(0, 48, 8, 2);

    // Test 5: reset during output line 1
    clear_state(0);
    gen_frame(0, 0);
    n = 0;
    while (win_cnt[0] < 8 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(win_cnt[0] >= 8, "reach_line1", 200'(win_cnt[0]), 200'(8));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pq_a.delete();
    eq_a.delete();
    clear_state(0);
    #1;
    chk(a_wvalid == 1'b0, "midreset_window_valid", 200'(a_wvalid), 200'(0));
    chk(a_pready == 1'b0, "midreset_pixel_ready", 200'(a_pready), 200'(0));
    chk(a_win == '0, "midreset_window", {128'b0, a_win}, 200'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk(a_pready == 1'b1, "ready_after_midreset", 200'(a_pready), 200'(1));
    gen_frame(0, 0);
    wait_done(0, 2000);
    check_counts(0, 24, 4, 1);

    // Test 6: K=5, width 7, six banks; two random frames with random stalls on both sides
    clear_state(1); rmode[1] = 1; vgap[1] = 1;
    gen_frame(1, 1);
    gen_frame(1, 1);
    wait_done(1, 20000);
    check_counts(1, 48, 16, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
